// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg
//   Shared definitions for the instruction fetch slice: the fetch FSM state
//   encoding, the RV32I / RVC opcode and funct3 values the predecoder looks
//   at, and the reset fetch address.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_QUERY = 2'd0,  // issue (or re-issue after reset/flush) an icache query
        ST_WAIT  = 2'd1,  // query outstanding, waiting for the icache response
        ST_HOLD  = 2'd2,  // response latched, instruction queue is full
        ST_STALL = 2'd3   // indirect jump pushed, target unknown until a flush
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // RV32I major opcodes and funct3 values
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [2:0] F3_JALR  = 3'b000;

    // RVC quadrants and funct3 values (RV32 encodings)
    localparam logic [1:0] RVC_Q1   = 2'b01;
    localparam logic [1:0] RVC_Q2   = 2'b10;
    localparam logic [2:0] C_F3_JAL = 3'b001;  // C.JAL, quadrant 1
    localparam logic [2:0] C_F3_J   = 3'b101;  // C.J, quadrant 1
    localparam logic [2:0] C_F3_JR  = 3'b100;  // C.JR / C.JALR / C.MV / C.ADD, quadrant 2

    // Any low-bit pair other than 2'b11 marks a 16-bit instruction.
    function automatic logic is_rvc(input logic [1:0] low_bits);
        return low_bits != 2'b11;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
//   Groups the icache query/response bus and the instruction-queue push bus.
//
//   Handshake semantics: ICache_query_en and IQ_push_en are single-cycle
//   pulses; the receiver must capture the accompanying data in the same
//   cycle. ICache_dout_en qualifies ICache_dout for exactly the cycles it is
//   high. IQ_full is a level-sensitive "not ready": while it is high the
//   fetch unit never pulses IQ_push_en.
//
//   master : fetch unit (drives queries and pushes)
//   slave  : icache + instruction queue side
interface instruction_fetch_if;
    logic        ICache_query_en;
    logic [31:0] ICache_query_addr;
    logic        ICache_dout_en;
    logic [31:0] ICache_dout;
    logic        IQ_full;
    logic        IQ_push_en;
    logic [31:0] IQ_inst;
    logic [31:0] IQ_pc;
    logic        IQ_is_compressed;
    logic        IQ_pred_taken;

    modport master (
        output ICache_query_en, ICache_query_addr,
        output IQ_push_en, IQ_inst, IQ_pc, IQ_is_compressed, IQ_pred_taken,
        input  ICache_dout_en, ICache_dout, IQ_full
    );

    modport slave (
        input  ICache_query_en, ICache_query_addr,
        input  IQ_push_en, IQ_inst, IQ_pc, IQ_is_compressed, IQ_pred_taken,
        output ICache_dout_en, ICache_dout, IQ_full
    );
endinterface

// File: rtl/instruction_fetch_inst_predecode.sv
// inst_predecode
//   Combinational predecoder for one fetched word.
//   inst          : raw 32-bit fetch word (a 16-bit instruction sits in [15:0])
//   pc            : address of the instruction
//   is_compressed : instruction is 16-bit
//   is_jump       : direct jump (JAL, C.J, C.JAL), target is known now
//   target        : pc + sign-extended jump immediate (valid when is_jump)
//   is_indirect   : register jump (JALR, C.JR, C.JALR), target unknown
module inst_predecode
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic        is_compressed,
    output logic        is_jump,
    output logic [31:0] target,
    output logic        is_indirect
);

    logic [31:0] imm_j;
    logic [31:0] imm_cj;
    logic [2:0]  c_f3;

    always_comb begin
        is_compressed = is_rvc(inst[1:0]);
        // J-type: imm[20|10:1|11|19:12]
        imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        // CJ-type: offset[11|4|9:8|10|6|7|3:1|5] in inst[12:2]
        imm_cj = {{21{inst[12]}}, inst[8], inst[10:9], inst[6], inst[7],
                  inst[2], inst[11], inst[5:3], 1'b0};
        c_f3        = inst[15:13];
        is_jump     = 1'b0;
        is_indirect = 1'b0;
        target      = pc + imm_j;
        if (is_compressed) begin
            target = pc + imm_cj;
            if (inst[1:0] == RVC_Q1 && (c_f3 == C_F3_J || c_f3 == C_F3_JAL))
                is_jump = 1'b1;
            // C.JR / C.JALR: rs1 != 0 and rs2 == 0; bit 12 only selects the link
            if (inst[1:0] == RVC_Q2 && c_f3 == C_F3_JR &&
                inst[11:7] != 5'd0 && inst[6:2] == 5'd0)
                is_indirect = 1'b1;
        end else begin
            if (inst[6:0] == OPC_JAL)
                is_jump = 1'b1;
            if (inst[6:0] == OPC_JALR && inst[14:12] == F3_JALR)
                is_indirect = 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetches one instruction per icache query, predecodes it, predicts direct
//   jumps as taken and pushes it into the instruction queue. Register jumps
//   park the unit in STALL until commit redirects it with a flush.
//   clk_in / rst_in : clock, asynchronous active-low reset
//   rdy_in          : global run enable, low freezes every register
//   flush_signal    : redirect from commit, fetch restarts at flush_pc
//   bus             : icache query/response and instruction-queue push signals
//   state_dbg       : current FSM state
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_signal,
    input  logic [31:0]         flush_pc,
    instruction_fetch_if.master bus,
    output fetch_state_t        state_dbg
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic         qen_q, qen_d;
    logic [31:0]  qaddr_q, qaddr_d;
    logic         push_q, push_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         isc_q, isc_d;
    logic         pred_q, pred_d;

    logic [31:0]  pd_inst;
    logic         pd_c, pd_jump, pd_indirect;
    logic [31:0]  pd_target;
    logic         do_push;

    // In HOLD the latched word is decoded, otherwise the live response.
    assign pd_inst = (state_q == ST_HOLD) ? hold_q : bus.ICache_dout;

    inst_predecode u_predecode (
        .inst          (pd_inst),
        .pc            (pc_q),
        .is_compressed (pd_c),
        .is_jump       (pd_jump),
        .target        (pd_target),
        .is_indirect   (pd_indirect)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        qen_d   = qen_q;
        qaddr_d = qaddr_q;
        push_d  = push_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        isc_d   = isc_q;
        pred_d  = pred_q;
        do_push = 1'b0;
        if (flush_signal) begin
            // Drops any held word or same-cycle response; overrides rdy_in.
            pc_d    = flush_pc;
            state_d = ST_QUERY;
            qen_d   = 1'b0;
            push_d  = 1'b0;
        end else if (rdy_in) begin
            qen_d  = 1'b0;
            push_d = 1'b0;
            case (state_q)
                ST_QUERY: begin
                    // QUERY is entered with the pulse already raised after a
                    // push; after reset/flush the pulse is raised here first.
                    if (qen_q) begin
                        state_d = ST_WAIT;
                    end else begin
                        qen_d   = 1'b1;
                        qaddr_d = pc_q;
                    end
                end
                ST_WAIT: begin
                    if (bus.ICache_dout_en) begin
                        if (bus.IQ_full) begin
                            hold_d  = bus.ICache_dout;
                            state_d = ST_HOLD;
                        end else begin
                            do_push = 1'b1;
                        end
                    end
                end
                ST_HOLD:  if (!bus.IQ_full) do_push = 1'b1;
                default:  ;  // STALL waits for a flush
            endcase
            if (do_push) begin
                push_d = 1'b1;
                inst_d = pd_c ? {16'h0000, pd_inst[15:0]} : pd_inst;
                ipc_d  = pc_q;
                isc_d  = pd_c;
                pred_d = pd_jump;
                pc_d   = pd_jump ? pd_target : (pc_q + (pd_c ? 32'd2 : 32'd4));
                if (pd_indirect) begin
                    state_d = ST_STALL;
                end else begin
                    // Query the next pc alongside the push: 2-cycle throughput.
                    state_d = ST_QUERY;
                    qen_d   = 1'b1;
                    qaddr_d = pc_d;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_QUERY;
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
            qen_q   <= 1'b0;
            qaddr_q <= 32'h0;
            push_q  <= 1'b0;
            inst_q  <= 32'h0;
            ipc_q   <= 32'h0;
            isc_q   <= 1'b0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            qen_q   <= qen_d;
            qaddr_q <= qaddr_d;
            push_q  <= push_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            isc_q   <= isc_d;
            pred_q  <= pred_d;
        end
    end

    assign bus.ICache_query_en   = qen_q;
    assign bus.ICache_query_addr = qaddr_q;
    assign bus.IQ_push_en        = push_q;
    assign bus.IQ_inst           = inst_q;
    assign bus.IQ_pc             = ipc_q;
    assign bus.IQ_is_compressed  = isc_q;
    assign bus.IQ_pred_taken     = pred_q;
    assign state_dbg             = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] ADDI = 32'h0010_0093;  // addi x1, x0, 1

    // ---------------- clock / reset ----------------
    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         rdy_in;
    logic         flush_signal;
    logic [31:0]  flush_pc;
    fetch_state_t state_dbg;

    always #5 clk_in = ~clk_in;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_signal (flush_signal),
        .flush_pc     (flush_pc),
        .bus          (bus.master),
        .state_dbg    (state_dbg)
    );

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    logic        pending;
    logic [31:0] pend_addr;
    logic        prev_q, prev_p;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] q_log[$];
    int          q_cyc[$];
    logic [31:0] p_pc[$];
    logic [31:0] p_inst[$];
    logic        p_c[$];
    logic        p_t[$];
    int          p_cyc[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ADDI;
    endfunction

    task automatic clear_logs();
        q_log.delete(); q_cyc.delete();
        p_pc.delete(); p_inst.delete(); p_c.delete(); p_t.delete(); p_cyc.delete();
        cyc = 0; prev_q = 1'b0; prev_p = 1'b0; pending = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0; flush_pc = 32'h0;
        bus.IQ_full = 1'b0; bus.ICache_dout_en = 1'b0; bus.ICache_dout = 32'hFFFF_FFFF;
        mem.delete();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        clear_logs();
    endtask

    task automatic redirect(input logic [31:0] pc);
        @(negedge clk_in);
        flush_signal = 1'b1; flush_pc = pc;
        bus.ICache_dout_en = 1'b0; bus.ICache_dout = 32'hFFFF_FFFF;
        @(negedge clk_in);
        flush_signal = 1'b0;
        clear_logs();
    endtask

    // One cycle: icache model with hit latency 1 (responds in the cycle after
    // the query pulse, frozen along with the DUT while rdy_in is low), plus
    // logging of query and push pulses.
    task automatic tick();
        logic last_rdy;
        @(negedge clk_in);
        cyc++;
        last_rdy = rdy_in;
        if (rdy_in) begin
            bus.ICache_dout_en = pending;
            bus.ICache_dout    = pending ? fetch_word(pend_addr) : 32'hFFFF_FFFF;
            pending   = bus.ICache_query_en;
            pend_addr = bus.ICache_query_addr;
        end else begin
            bus.ICache_dout_en = 1'b0;
            bus.ICache_dout    = 32'hFFFF_FFFF;
        end
        if (last_rdy) begin
            if (bus.ICache_query_en) begin
                q_log.push_back(bus.ICache_query_addr); q_cyc.push_back(cyc);
                if (prev_q) viol++;
            end
            if (bus.IQ_push_en) begin
                p_pc.push_back(bus.IQ_pc); p_inst.push_back(bus.IQ_inst);
                p_c.push_back(bus.IQ_is_compressed); p_t.push_back(bus.IQ_pred_taken);
                p_cyc.push_back(cyc);
                if (prev_p) viol++;
            end
            prev_q = bus.ICache_query_en;
            prev_p = bus.IQ_push_en;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0; flush_pc = 32'h0;
        bus.IQ_full = 1'b0; bus.ICache_dout_en = 1'b0; bus.ICache_dout = 32'hFFFF_FFFF;
        @(negedge clk_in);
        checks++;
        if ({bus.ICache_query_en, bus.IQ_push_en, bus.IQ_is_compressed, bus.IQ_pred_taken} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0000",
                {bus.ICache_query_en, bus.IQ_push_en, bus.IQ_is_compressed, bus.IQ_pred_taken});
        end
        checks++;
        if ({bus.ICache_query_addr, bus.IQ_inst, bus.IQ_pc} !== 96'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected zeros",
                bus.ICache_query_addr, bus.IQ_inst, bus.IQ_pc);
        end
        checks++;
        if (state_dbg !== ST_QUERY) begin
            errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_QUERY);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        repeat (8) tick();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        checks++;
        if (q_cyc[0] !== 1) begin
            errors++; $display("FAIL seq_first_query_cycle: got %0d expected 1", q_cyc[0]);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (q_log[i] !== e) begin
                errors++; $display("FAIL seq_query_addr[%0d]: got %h expected %h", i, q_log[i], e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (p_pc[i] !== 32'(4 * i) || p_inst[i] !== ADDI || p_c[i] !== 1'b0 || p_cyc[i] !== 3 + 2 * i) begin
                errors++; $display("FAIL seq_push[%0d]: got pc %h inst %h c %b cyc %0d expected pc %h inst %h c 0 cyc %0d",
                    i, p_pc[i], p_inst[i], p_c[i], p_cyc[i], 32'(4 * i), ADDI, 3 + 2 * i);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) tick();
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({bus.IQ_push_en, bus.ICache_query_en} !== 2'b00 || bus.IQ_inst !== 32'h0 ||
            bus.ICache_query_addr !== 32'h0 || state_dbg !== ST_QUERY) begin
            errors++; $display("FAIL async_reset: got push %b query %b inst %h addr %h state %0d expected all zero, state 0",
                bus.IQ_push_en, bus.ICache_query_en, bus.IQ_inst, bus.ICache_query_addr, state_dbg);
        end
    endtask

    task automatic test_compressed();
        do_reset();
        mem[32'h10] = 32'h0001_0001;
        redirect(32'h10);
        repeat (4) tick();
        checks++;
        if (p_pc[0] !== 32'h10 || p_c[0] !== 1'b1 || p_t[0] !== 1'b0) begin
            errors++; $display("FAIL cnop_push: got pc %h c %b t %b expected pc 00000010 c 1 t 0", p_pc[0], p_c[0], p_t[0]);
        end
        checks++;
        if (p_inst[0] !== 32'h0000_0001) begin
            errors++; $display("FAIL cnop_inst: got %h expected 00000001", p_inst[0]);
        end
        checks++;
        if (q_log[1] !== 32'h12) begin
            errors++; $display("FAIL cnop_next_query: got %h expected 00000012", q_log[1]);
        end
    endtask

    task automatic test_jumps();
        do_reset();
        mem[32'h20]  = 32'h1000_006F;  // jal x0, +0x100
        mem[32'h120] = 32'hDEAD_BFF5;  // c.j -4, junk upper half
        redirect(32'h20);
        repeat (6) tick();
        checks++;
        if (p_pc[0] !== 32'h20 || p_t[0] !== 1'b1 || p_inst[0] !== 32'h1000_006F) begin
            errors++; $display("FAIL jal_push: got pc %h t %b inst %h expected pc 00000020 t 1 inst 1000006f", p_pc[0], p_t[0], p_inst[0]);
        end
        checks++;
        if (q_log[1] !== 32'h120) begin
            errors++; $display("FAIL jal_target: got %h expected 00000120", q_log[1]);
        end
        checks++;
        if (p_pc[1] !== 32'h120 || p_inst[1] !== 32'h0000_BFF5 || p_c[1] !== 1'b1 || p_t[1] !== 1'b1) begin
            errors++; $display("FAIL cj_push: got pc %h inst %h c %b t %b expected pc 00000120 inst 0000bff5 c 1 t 1",
                p_pc[1], p_inst[1], p_c[1], p_t[1]);
        end
        checks++;
        if (q_log[2] !== 32'h11C) begin
            errors++; $display("FAIL cj_back_target: got %h expected 0000011c", q_log[2]);
        end
    endtask

    task automatic test_iq_full();
        do_reset();
        redirect(32'h30);
        bus.IQ_full = 1'b1;
        repeat (6) tick();
        checks++;
        if (p_pc.size() !== 0 || state_dbg !== ST_HOLD) begin
            errors++; $display("FAIL full_no_push: got %0d pushes state %0d expected 0 pushes state %0d", p_pc.size(), state_dbg, ST_HOLD);
        end
        bus.IQ_full = 1'b0;
        repeat (2) tick();
        checks++;
        if (p_pc.size() !== 1) begin
            errors++; $display("FAIL full_push_count: got %0d expected 1", p_pc.size());
        end
        checks++;
        if (p_pc[0] !== 32'h30 || p_inst[0] !== ADDI || p_cyc[0] !== 7) begin
            errors++; $display("FAIL full_push_data: got pc %h inst %h cyc %0d expected pc 00000030 inst %h cyc 7",
                p_pc[0], p_inst[0], p_cyc[0], ADDI);
        end
    endtask

    task automatic test_jalr_stall();
        do_reset();
        mem[32'h40] = 32'h0000_8067;  // jalr x0, 0(x1)
        redirect(32'h40);
        repeat (8) tick();
        checks++;
        if (p_pc.size() !== 1 || p_pc[0] !== 32'h40 || p_inst[0] !== 32'h0000_8067 || p_t[0] !== 1'b0) begin
            errors++; $display("FAIL jalr_push: got n %0d pc %h inst %h t %b expected n 1 pc 00000040 inst 00008067 t 0",
                p_pc.size(), p_pc[0], p_inst[0], p_t[0]);
        end
        checks++;
        if (q_log.size() !== 1 || state_dbg !== ST_STALL) begin
            errors++; $display("FAIL jalr_stall: got %0d queries state %0d expected 1 query state %0d", q_log.size(), state_dbg, ST_STALL);
        end
        // stray response while stalled must be ignored
        @(negedge clk_in);
        bus.ICache_dout_en = 1'b1; bus.ICache_dout = ADDI;
        repeat (2) tick();
        checks++;
        if (p_pc.size() !== 1 || q_log.size() !== 1) begin
            errors++; $display("FAIL stall_stray: got %0d pushes %0d queries expected 1 and 1", p_pc.size(), q_log.size());
        end
        redirect(32'h80);
        tick();
        checks++;
        if (q_log[0] !== 32'h80 || q_cyc[0] !== 1) begin
            errors++; $display("FAIL jalr_flush_query: got %h at cyc %0d expected 00000080 at cyc 1", q_log[0], q_cyc[0]);
        end
    endtask

    task automatic test_flush_collision();
        do_reset();
        redirect(32'h50);
        repeat (2) tick();  // response is on the bus during cycle 2
        flush_signal = 1'b1; flush_pc = 32'h200;
        tick();
        flush_signal = 1'b0;
        checks++;
        if (p_pc.size() !== 0) begin
            errors++; $display("FAIL flush_drop_push: got %0d pushes expected 0", p_pc.size());
        end
        repeat (3) tick();
        checks++;
        if (q_log[1] !== 32'h200 || q_cyc[1] !== 4) begin
            errors++; $display("FAIL flush_query: got %h at cyc %0d expected 00000200 at cyc 4", q_log[1], q_cyc[1]);
        end
        checks++;
        if (p_pc.size() !== 1 || p_pc[0] !== 32'h200) begin
            errors++; $display("FAIL flush_push: got n %0d pc %h expected n 1 pc 00000200", p_pc.size(), p_pc[0]);
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        redirect(32'h60);
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.ICache_query_en !== 1'b1 || bus.ICache_query_addr !== 32'h60) begin
                errors++; $display("FAIL rdy_hold[%0d]: got en %b addr %h expected en 1 addr 00000060",
                    i, bus.ICache_query_en, bus.ICache_query_addr);
            end
        end
        rdy_in = 1'b1;
        repeat (2) tick();
        checks++;
        if (p_pc.size() !== 1 || p_pc[0] !== 32'h60 || p_cyc[0] !== 6 || q_log.size() !== 2 || q_log[1] !== 32'h64) begin
            errors++; $display("FAIL rdy_resume: got n %0d pc %h cyc %0d nq %0d q1 %h expected n 1 pc 00000060 cyc 6 nq 2 q1 00000064",
                p_pc.size(), p_pc[0], p_cyc[0], q_log.size(), q_log[1]);
        end
    endtask

    task automatic test_pulse_rule();
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL pulse_consecutive: got %0d violations expected 0", viol);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_async_reset();
        test_compressed();
        test_jumps();
        test_iq_full();
        test_jalr_stall();
        test_flush_collision();
        test_rdy_freeze();
        test_pulse_rule();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
